// File: rtl/eep_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eep_arb_pkg
//  Brief    : Shared widths, FSM encoding and round-robin helper for the
//             EEPROM access arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package eep_arb_pkg;

   localparam int ADDR_W = 24;
   localparam int LEN_W  = 10;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_XFER      = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/eep_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : eep_rr_arbiter
//  Brief    : Round-robin pick of the first request at/after the pointer;
//             pointer moves past the last owner when advanced.
//  Revision : 1.0  initial release
// ============================================================================
module eep_rr_arbiter
   import eep_arb_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_i,
   input  logic                     adv_i,
   input  logic [$clog2(NREQ)-1:0]  last_i,
   output logic [NREQ-1:0]          gnt_oh_o,
   output logic [$clog2(NREQ)-1:0]  gnt_idx_o
);

   localparam int IDX_W = $clog2(NREQ);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic             found;

   always_comb begin : p_pick
      int unsigned s;
      s         = 0;
      found     = 1'b0;
      gnt_idx_o = '0;
      gnt_oh_o  = '0;
      for (int k = 0; k < NREQ; k++) begin
         s = 32'(ptr_q) + 32'(k);
         if (s >= NREQ) s = s - NREQ;
         if (!found && req_i[IDX_W'(s)]) begin
            found     = 1'b1;
            gnt_idx_o = IDX_W'(s);
         end
      end
      gnt_oh_o[gnt_idx_o] = found;
   end

   assign ptr_d = IDX_W'(rr_next(32'(last_i), NREQ));

   always_ff @(posedge clk) begin
      if (!rst_n)     ptr_q <= '0;
      else if (adv_i) ptr_q <= ptr_d;
   end

endmodule
`default_nettype wire

// File: rtl/eep_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : eep_access_arbiter
//  Brief    : Round-robin sharing of one spi_eeprom_iface between NREQ
//             requesters; optional XFER watchdog via EEP_ARB_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module eep_access_arbiter
   import eep_arb_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int BUSY_WAIT = 16,
   parameter int TMO_CYC   = 1 << 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_vld_i,
   input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
   input  logic [NREQ-1:0]          req_wr_rd_n_i,
   input  logic [NREQ*LEN_W-1:0]    req_len_i,
   output logic [NREQ-1:0]          req_gnt_o,
   input  logic [NREQ*DATA_W-1:0]   req_wdata_i,
   input  logic [NREQ-1:0]          req_wdata_vld_i,
   output logic [NREQ-1:0]          req_wdata_rdy_o,
   output logic [DATA_W-1:0]        req_rdata_o,
   output logic [NREQ-1:0]          req_rdata_vld_o,
   input  logic [NREQ-1:0]          req_rdata_rdy_i,
   output logic [NREQ-1:0]          req_done_o,
   output logic [NREQ-1:0]          req_err_o,
   output logic [ADDR_W-1:0]        eep_addr_o,
   output logic                     eep_addr_vld_o,
   output logic                     eep_wr_rd_n_o,
   output logic [LEN_W-1:0]         eep_data_len_o,
   output logic [DATA_W-1:0]        eep_wdata_o,
   output logic                     eep_wdata_vld_o,
   output logic                     eep_rdata_rdy_o,
   input  logic [DATA_W-1:0]        eep_rdata_i,
   input  logic                     eep_rdata_vld_i,
   input  logic                     eep_wdata_rdy_i,
   input  logic                     eep_busy_i,
   input  logic [LEN_W-1:0]         eep_data_cntr_i,
   output logic [LEN_W-1:0]         dbg_data_cntr_o
);

   localparam int IDX_W   = $clog2(NREQ);
   // One counter serves both the busy-rise wait and the XFER watchdog.
   localparam int CNT_MAX = (TMO_CYC > BUSY_WAIT) ? TMO_CYC : BUSY_WAIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t             state_q;
   logic [IDX_W-1:0]   owner_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [LEN_W-1:0]   len_q;
   logic               wr_q;
   logic               addr_vld_q;
   logic [NREQ-1:0]    gnt_q, done_q, err_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [LEN_W-1:0]   dbg_q;
   logic               drain;

   logic [NREQ-1:0]    gnt_oh, owner_oh;
   logic [IDX_W-1:0]   gnt_idx;
   logic [ADDR_W-1:0]  sel_addr;
   logic [LEN_W-1:0]   sel_len;
   logic               sel_wr;
   logic [DATA_W-1:0]  own_wdata;
   logic               own_wdata_vld, own_rdata_rdy, in_xfer;

   eep_rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_vld_i),
      .adv_i     (state_q == ST_DONE),
      .last_i    (owner_q),
      .gnt_oh_o  (gnt_oh),
      .gnt_idx_o (gnt_idx)
   );

   always_comb begin
      sel_addr      = '0;
      sel_len       = '0;
      sel_wr        = 1'b0;
      own_wdata     = '0;
      own_wdata_vld = 1'b0;
      own_rdata_rdy = 1'b0;
      owner_oh      = '0;
      owner_oh[owner_q] = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDX_W'(i)) begin
            sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
            sel_len  = req_len_i[i*LEN_W +: LEN_W];
            sel_wr   = req_wr_rd_n_i[i];
         end
         if (owner_q == IDX_W'(i)) begin
            own_wdata     = req_wdata_i[i*DATA_W +: DATA_W];
            own_wdata_vld = req_wdata_vld_i[i];
            own_rdata_rdy = req_rdata_rdy_i[i];
         end
      end
   end

   assign in_xfer = (state_q == ST_XFER);

   assign req_gnt_o       = gnt_q;
   assign req_done_o      = done_q;
   assign req_err_o       = err_q;
   assign eep_addr_o      = addr_q;
   assign eep_addr_vld_o  = addr_vld_q;
   assign eep_wr_rd_n_o   = wr_q;
   assign eep_data_len_o  = len_q;
   assign dbg_data_cntr_o = dbg_q;
   assign eep_wdata_o     = in_xfer ? own_wdata : '0;
   assign eep_wdata_vld_o = in_xfer & own_wdata_vld;
   assign eep_rdata_rdy_o = (in_xfer & own_rdata_rdy) | drain;
   assign req_wdata_rdy_o = (in_xfer & eep_wdata_rdy_i) ? owner_oh : '0;
   assign req_rdata_vld_o = (in_xfer & eep_rdata_vld_i) ? owner_oh : '0;
   assign req_rdata_o     = in_xfer ? eep_rdata_i : '0;

`ifdef EEP_ARB_TIMEOUT_EN
   logic drain_q;
   assign drain = drain_q;
`else
   assign drain = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         wr_q       <= 1'b0;
         addr_vld_q <= 1'b0;
         gnt_q      <= '0;
         done_q     <= '0;
         err_q      <= '0;
         cnt_q      <= '0;
         dbg_q      <= '0;
`ifdef EEP_ARB_TIMEOUT_EN
         drain_q    <= 1'b0;
`endif
      end else begin
         gnt_q      <= '0;
         done_q     <= '0;
         err_q      <= '0;
         addr_vld_q <= 1'b0;
         dbg_q      <= eep_data_cntr_i;
         case (state_q)
            ST_IDLE: begin
               if (|req_vld_i && !eep_busy_i) begin
                  owner_q <= gnt_idx;
                  addr_q  <= sel_addr;
                  len_q   <= sel_len;
                  wr_q    <= sel_wr;
                  gnt_q   <= gnt_oh;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // Zero-length requests are refused without touching the iface.
               if (len_q == '0) begin
                  done_q  <= owner_oh;
                  err_q   <= owner_oh;
                  state_q <= ST_DONE;
               end else begin
                  addr_vld_q <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= ST_WAIT_BUSY;
               end
            end
            ST_WAIT_BUSY: begin
               if (eep_busy_i) begin
                  cnt_q   <= '0;
                  state_q <= ST_XFER;
               end else if (cnt_q == CNT_W'(BUSY_WAIT - 1)) begin
                  done_q  <= owner_oh;
                  err_q   <= owner_oh;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_XFER: begin
               if (!eep_busy_i) begin
                  done_q  <= owner_oh;
                  state_q <= ST_DONE;
               end
`ifdef EEP_ARB_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
                  done_q  <= owner_oh;
                  err_q   <= owner_oh;
                  drain_q <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            ST_DONE: begin
`ifdef EEP_ARB_TIMEOUT_EN
               // After a watchdog abort, keep accepting bytes until the iface idles.
               if (!drain_q || !eep_busy_i) begin
                  drain_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
`else
               state_q <= ST_IDLE;
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_eep_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eep_access_arbiter
//  Brief    : Directed self-checking bench for eep_access_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eep_access_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_vld, req_wr_rd_n, req_gnt, req_wdata_vld, req_wdata_rdy;
   logic [1:0]  req_rdata_vld, req_rdata_rdy, req_done, req_err;
   logic [47:0] req_addr;
   logic [19:0] req_len;
   logic [15:0] req_wdata;
   logic [7:0]  req_rdata, eep_wdata, eep_rdata;
   logic [23:0] eep_addr;
   logic        eep_addr_vld, eep_wr_rd_n, eep_wdata_vld, eep_rdata_rdy;
   logic        eep_rdata_vld, eep_wdata_rdy, eep_busy;
   logic [9:0]  eep_data_len, eep_data_cntr, dbg_data_cntr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   eep_access_arbiter #(.NREQ(2), .BUSY_WAIT(16), .TMO_CYC(64)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_vld_i       (req_vld),
      .req_addr_i      (req_addr),
      .req_wr_rd_n_i   (req_wr_rd_n),
      .req_len_i       (req_len),
      .req_gnt_o       (req_gnt),
      .req_wdata_i     (req_wdata),
      .req_wdata_vld_i (req_wdata_vld),
      .req_wdata_rdy_o (req_wdata_rdy),
      .req_rdata_o     (req_rdata),
      .req_rdata_vld_o (req_rdata_vld),
      .req_rdata_rdy_i (req_rdata_rdy),
      .req_done_o      (req_done),
      .req_err_o       (req_err),
      .eep_addr_o      (eep_addr),
      .eep_addr_vld_o  (eep_addr_vld),
      .eep_wr_rd_n_o   (eep_wr_rd_n),
      .eep_data_len_o  (eep_data_len),
      .eep_wdata_o     (eep_wdata),
      .eep_wdata_vld_o (eep_wdata_vld),
      .eep_rdata_rdy_o (eep_rdata_rdy),
      .eep_rdata_i     (eep_rdata),
      .eep_rdata_vld_i (eep_rdata_vld),
      .eep_wdata_rdy_i (eep_wdata_rdy),
      .eep_busy_i      (eep_busy),
      .eep_data_cntr_i (eep_data_cntr),
      .dbg_data_cntr_o (dbg_data_cntr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one transaction with a well-behaved iface; reports what it saw.
   task automatic serve(output logic [1:0] g, output int av, output logic [1:0] d);
      g = '0; av = 0; d = '0;
      for (int i = 0; i < 20 && g == 2'b00; i++) begin
         tick();
         if (req_gnt != 2'b00) g = req_gnt;
      end
      if (g == 2'b00) return;
      req_vld = req_vld & ~g;
      for (int i = 0; i < 4 && av == 0; i++) begin
         tick();
         if (eep_addr_vld) av++;
      end
      eep_busy = 1'b1;
      repeat (2) begin
         tick();
         if (eep_addr_vld) av++;
      end
      eep_busy = 1'b0;
      for (int i = 0; i < 6 && d == 2'b00; i++) begin
         tick();
         if (eep_addr_vld) av++;
         d = req_done;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_vld = 2'b01;
      tick(); tick();
      n_checks++; if (req_gnt !== 2'b00) begin n_errors++; $display("FAIL reset_gnt: got %b want 00", req_gnt); end
      n_checks++; if ({eep_addr_vld, req_done, req_err} !== 5'b0) begin n_errors++; $display("FAIL reset_pulses: got %b want 00000", {eep_addr_vld, req_done, req_err}); end
      n_checks++; if ({eep_addr, eep_data_len} !== 34'h0) begin n_errors++; $display("FAIL reset_addr_len: got %h want 0", {eep_addr, eep_data_len}); end
      n_checks++; if (eep_rdata_rdy !== 1'b0) begin n_errors++; $display("FAIL reset_rdata_rdy: got %b want 0", eep_rdata_rdy); end
      req_vld = 2'b00;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      req_addr[23:0] = 24'h123456; req_len[9:0] = 10'd2; req_wr_rd_n[0] = 1'b1;
      req_vld = 2'b01;
      tick();
      n_checks++; if (req_gnt !== 2'b01) begin n_errors++; $display("FAIL wr_gnt: got %b want 01", req_gnt); end
      req_vld = 2'b00;
      tick();
      n_checks++; if ({eep_addr_vld, eep_wr_rd_n, eep_addr, eep_data_len} !== {1'b1, 1'b1, 24'h123456, 10'd2})
         begin n_errors++; $display("FAIL wr_issue: got %b %b %h %0d want 1 1 123456 2", eep_addr_vld, eep_wr_rd_n, eep_addr, eep_data_len); end
      eep_busy = 1'b1;
      tick();
      n_checks++; if (eep_addr_vld !== 1'b0) begin n_errors++; $display("FAIL wr_addr_vld_once: got %b want 0", eep_addr_vld); end
      req_wdata[7:0] = 8'h55; req_wdata_vld = 2'b01; eep_wdata_rdy = 1'b1;
      #1;
      n_checks++; if ({eep_wdata_vld, eep_wdata} !== {1'b1, 8'h55}) begin n_errors++; $display("FAIL wr_beat0: got %b %h want 1 55", eep_wdata_vld, eep_wdata); end
      n_checks++; if (req_wdata_rdy !== 2'b01) begin n_errors++; $display("FAIL wr_rdy_owner: got %b want 01", req_wdata_rdy); end
      tick();
      req_wdata = 16'hAA88; req_wdata_vld = 2'b11;
      #1;
      n_checks++; if ({eep_wdata_vld, eep_wdata} !== {1'b1, 8'h88}) begin n_errors++; $display("FAIL wr_beat1: got %b %h want 1 88", eep_wdata_vld, eep_wdata); end
      tick();
      req_wdata_vld = 2'b00; eep_wdata_rdy = 1'b0; eep_busy = 1'b0;
      tick();
      n_checks++; if ({req_done, req_err} !== 4'b0100) begin n_errors++; $display("FAIL wr_done: got %b %b want 01 00", req_done, req_err); end
      tick();
      n_checks++; if (req_done !== 2'b00) begin n_errors++; $display("FAIL wr_done_pulse: got %b want 00", req_done); end
   endtask

   task automatic test_read();
      logic [7:0] rb [4];
      rb = '{8'h12, 8'h34, 8'h56, 8'h78};
      req_addr[47:24] = 24'h000100; req_len[19:10] = 10'd4; req_wr_rd_n[1] = 1'b0;
      eep_data_cntr = 10'h2A5;
      req_vld = 2'b10;
      tick();
      n_checks++; if (req_gnt !== 2'b10) begin n_errors++; $display("FAIL rd_gnt: got %b want 10", req_gnt); end
      req_vld = 2'b00;
      tick();
      n_checks++; if ({eep_addr_vld, eep_wr_rd_n, eep_addr, eep_data_len} !== {1'b1, 1'b0, 24'h000100, 10'd4})
         begin n_errors++; $display("FAIL rd_issue: got %b %b %h %0d want 1 0 000100 4", eep_addr_vld, eep_wr_rd_n, eep_addr, eep_data_len); end
      n_checks++; if (dbg_data_cntr !== 10'h2A5) begin n_errors++; $display("FAIL rd_dbg_cntr: got %h want 2a5", dbg_data_cntr); end
      eep_busy = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         eep_rdata = rb[i]; eep_rdata_vld = 1'b1; req_rdata_rdy = 2'b11;
         #1;
         n_checks++; if ({req_rdata, req_rdata_vld, eep_rdata_rdy} !== {rb[i], 2'b10, 1'b1})
            begin n_errors++; $display("FAIL rd_byte%0d: got %h %b %b want %h 10 1", i, req_rdata, req_rdata_vld, eep_rdata_rdy, rb[i]); end
         tick();
      end
      req_rdata_rdy = 2'b01;
      #1;
      n_checks++; if (eep_rdata_rdy !== 1'b0) begin n_errors++; $display("FAIL rd_nonowner_rdy: got %b want 0", eep_rdata_rdy); end
      eep_rdata_vld = 1'b0; req_rdata_rdy = 2'b00; eep_busy = 1'b0;
      tick();
      n_checks++; if ({req_done, req_err} !== 4'b1000) begin n_errors++; $display("FAIL rd_done: got %b %b want 10 00", req_done, req_err); end
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] g, d;
      int av;
      logic [1:0] exp_g [5];
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
      req_vld = 2'b11;
      for (int t = 0; t < 5; t++) begin
         serve(g, av, d);
         n_checks++; if (g !== exp_g[t]) begin n_errors++; $display("FAIL rr_gnt%0d: got %b want %b", t, g, exp_g[t]); end
         n_checks++; if (av !== 1) begin n_errors++; $display("FAIL rr_addr_vld%0d: got %0d pulses want 1", t, av); end
         n_checks++; if (d !== exp_g[t]) begin n_errors++; $display("FAIL rr_done%0d: got %b want %b", t, d, exp_g[t]); end
         // Requester 0 re-asserts during its DONE cycle; second round starts fresh.
         if (t == 0) req_vld = 2'b11;
         if (t == 2) req_vld = 2'b11;
      end
      tick();
   endtask

   task automatic test_busy_timeout();
      int n;
      req_vld = 2'b01;
      tick();
      n_checks++; if (req_gnt !== 2'b01) begin n_errors++; $display("FAIL bw_gnt: got %b want 01", req_gnt); end
      req_vld = 2'b00;
      tick();
      n_checks++; if (eep_addr_vld !== 1'b1) begin n_errors++; $display("FAIL bw_addr_vld: got %b want 1", eep_addr_vld); end
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n++;
         if (req_done != 2'b00) break;
      end
      n_checks++; if (n !== 16) begin n_errors++; $display("FAIL bw_cycles: got %0d want 16", n); end
      n_checks++; if ({req_done, req_err} !== 4'b0101) begin n_errors++; $display("FAIL bw_done_err: got %b %b want 01 01", req_done, req_err); end
      tick();
      n_checks++; if (req_done !== 2'b00) begin n_errors++; $display("FAIL bw_done_pulse: got %b want 00", req_done); end
   endtask

   task automatic test_len_zero();
      req_len[19:10] = 10'd0;
      req_vld = 2'b10;
      tick();
      n_checks++; if (req_gnt !== 2'b10) begin n_errors++; $display("FAIL lz_gnt: got %b want 10", req_gnt); end
      req_vld = 2'b00;
      tick();
      n_checks++; if ({req_done, req_err, eep_addr_vld} !== 5'b10100) begin n_errors++; $display("FAIL lz_done_err: got %b %b %b want 10 10 0", req_done, req_err, eep_addr_vld); end
      tick();
      req_len[19:10] = 10'd4;
   endtask

   task automatic test_reset_mid();
      req_vld = 2'b01;
      tick();
      req_vld = 2'b00;
      tick();
      eep_busy = 1'b1;
      tick();
      req_wdata_vld = 2'b01; eep_wdata_rdy = 1'b1;
      #1;
      n_checks++; if (req_wdata_rdy !== 2'b01) begin n_errors++; $display("FAIL rm_pre_rdy: got %b want 01", req_wdata_rdy); end
      rst_n = 1'b0;
      tick();
      n_checks++; if ({req_wdata_rdy, eep_wdata_vld, eep_addr, eep_data_len} !== 37'h0)
         begin n_errors++; $display("FAIL rm_outputs: got %b %b %h %0d want 0", req_wdata_rdy, eep_wdata_vld, eep_addr, eep_data_len); end
      rst_n = 1'b1; eep_busy = 1'b0; req_wdata_vld = 2'b00; eep_wdata_rdy = 1'b0;
      req_vld = 2'b10;
      tick();
      n_checks++; if (req_gnt !== 2'b10) begin n_errors++; $display("FAIL rm_new_gnt: got %b want 10", req_gnt); end
      req_vld = 2'b00;
      tick();
      n_checks++; if (eep_addr_vld !== 1'b1) begin n_errors++; $display("FAIL rm_new_addr_vld: got %b want 1", eep_addr_vld); end
      eep_busy = 1'b1;
      tick();
      eep_busy = 1'b0;
      tick();
      n_checks++; if (req_done !== 2'b10) begin n_errors++; $display("FAIL rm_new_done: got %b want 10", req_done); end
      tick();
   endtask

`ifdef EEP_ARB_TIMEOUT_EN
   task automatic test_xfer_timeout();
      int n;
      req_wr_rd_n[0] = 1'b0;
      req_vld = 2'b01;
      tick();
      req_vld = 2'b00;
      tick();
      eep_busy = 1'b1; eep_rdata_vld = 1'b1; req_rdata_rdy = 2'b00;
      tick();
      n = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         n++;
         if (req_done != 2'b00) break;
      end
      n_checks++; if (n !== 64) begin n_errors++; $display("FAIL to_cycles: got %0d want 64", n); end
      n_checks++; if ({req_done, req_err} !== 4'b0101) begin n_errors++; $display("FAIL to_done_err: got %b %b want 01 01", req_done, req_err); end
      n_checks++; if (eep_rdata_rdy !== 1'b1) begin n_errors++; $display("FAIL to_drain: got %b want 1", eep_rdata_rdy); end
      tick();
      n_checks++; if (eep_rdata_rdy !== 1'b1) begin n_errors++; $display("FAIL to_drain_hold: got %b want 1", eep_rdata_rdy); end
      eep_busy = 1'b0; eep_rdata_vld = 1'b0;
      tick();
      n_checks++; if (eep_rdata_rdy !== 1'b0) begin n_errors++; $display("FAIL to_idle: got %b want 0", eep_rdata_rdy); end
   endtask
`endif

   initial begin
      rst_n = 1'b0; req_vld = '0; req_addr = '0; req_wr_rd_n = '0; req_len = '0;
      req_wdata = '0; req_wdata_vld = '0; req_rdata_rdy = '0;
      eep_rdata = '0; eep_rdata_vld = 1'b0; eep_wdata_rdy = 1'b0; eep_busy = 1'b0;
      eep_data_cntr = '0;
      test_reset();
      test_single_write();
      test_read();
      test_round_robin();
      test_busy_timeout();
      test_len_zero();
      test_reset_mid();
`ifdef EEP_ARB_TIMEOUT_EN
      test_xfer_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
